bist_sig_checker: RTL and testbench

- Downstream BIST session controller for the serial signature analyzer.
- Sequences one test session: reseeds the analyzer, enables it for exactly LEN serial-response cycles, then captures the final signature and compares it against a golden value.
- Reports done/pass to the top-level BIST control.
- Sits between the analyzer's signature output and the test-mode status logic.

---
 rtl/bist_sig_checker_pkg.sv | 34 +++
 rtl/bist_sig_checker.sv | 86 ++++++++
 tb/tb_bist_sig_checker.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/bist_sig_checker_pkg.sv
// Shared BIST session definitions: FSM states, default geometry, golden signature
// and the state-to-control decode used by the session checker.
package bist_sig_checker_pkg;

  localparam int          BIST_N      = 10;
  localparam int          BIST_LEN    = 24;
  localparam logic [9:0]  BIST_GOLDEN = 10'h2A5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEED,
    ST_RUN,
    ST_CHECK,
    ST_DONE
  } bist_state_e;

  typedef struct packed {
    logic sisa_rst;
    logic sisa_en;
    logic busy;
    logic done;
  } bist_ctl_t;

  function automatic bist_ctl_t bist_decode(bist_state_e st);
    bist_ctl_t c;
    c          = '0;
    c.sisa_rst = (st == ST_SEED);
    c.sisa_en  = (st == ST_RUN);
    c.busy     = (st != ST_IDLE);
    c.done     = (st == ST_DONE);
    return c;
  endfunction

endpackage

// File: rtl/bist_sig_checker.sv
// BIST session controller: reseeds the signature analyzer, enables it for LEN
// cycles, then captures the final signature and compares it to the golden value.
module bist_sig_checker
  import bist_sig_checker_pkg::*;
#(
  parameter int N   = BIST_N,
  parameter int LEN = BIST_LEN,
  parameter int CW  = $clog2(LEN + 1)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic         abort_i,
  input  logic [N-1:0] golden_i,
  input  logic [N-1:0] sig_in_i,
  output logic         sisa_rst_o,
  output logic         sisa_en_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         pass_o,
  output logic [N-1:0] sig_q_o
);

  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  bist_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  bist_ctl_t     ctl_q;
  logic          pass_q;
  logic [N-1:0]  sig_q;
  logic          abort_hit;

  assign abort_hit = abort_i &&
                     (state_q == ST_SEED || state_q == ST_RUN || state_q == ST_CHECK);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_SEED;
      ST_SEED:  state_d = ST_RUN;
      ST_RUN:   if (cnt_q == LAST) state_d = ST_CHECK;
      ST_CHECK: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (abort_hit) state_d = ST_IDLE;
  end

  // Counter saturates at LAST so it never wraps between sessions.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_SEED)
      cnt_d = '0;
    else if (state_q == ST_RUN && cnt_q != LAST)
      cnt_d = cnt_q + 1'b1;
  end

  // Outputs are decoded from the next state so they are valid for the whole state cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ctl_q   <= '0;
      pass_q  <= 1'b0;
      sig_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctl_q   <= bist_decode(state_d);
      if (state_q == ST_CHECK && state_d == ST_DONE) begin
        sig_q  <= sig_in_i;
        pass_q <= (sig_in_i == golden_i);
      end else if (abort_hit || state_d == ST_SEED) begin
        pass_q <= 1'b0;
      end
    end
  end

  assign sisa_rst_o = ctl_q.sisa_rst;
  assign sisa_en_o  = ctl_q.sisa_en;
  assign busy_o     = ctl_q.busy;
  assign done_o     = ctl_q.done;
  assign pass_o     = pass_q;
  assign sig_q_o    = sig_q;

endmodule

// File: tb/tb_bist_sig_checker.sv
// Bench for bist_sig_checker: a LEN=24 and a LEN=1 instance share stimulus and are
// checked every cycle against a session-timeline reference model.
module tb_bist_sig_checker;

  logic       clk;
  logic       rst_n;
  logic       start, abort;
  logic [9:0] golden, sig_in;

  logic       sr [2];
  logic       en [2];
  logic       bs [2];
  logic       dn [2];
  logic       ps [2];
  logic [9:0] sq [2];

  int n_err = 0;
  int n_chk = 0;
  int edge_n = 0;

  int         len_m [2] = '{24, 1};
  bit         m_act [2];
  int         m_k   [2];
  bit         m_pass[2];
  logic [9:0] m_sig [2];
  int         last_done[2];
  int         done_cnt [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bist_sig_checker #(.N(10), .LEN(24)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
    .golden_i(golden), .sig_in_i(sig_in),
    .sisa_rst_o(sr[0]), .sisa_en_o(en[0]), .busy_o(bs[0]), .done_o(dn[0]),
    .pass_o(ps[0]), .sig_q_o(sq[0])
  );

  bist_sig_checker #(.N(10), .LEN(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
    .golden_i(golden), .sig_in_i(sig_in),
    .sisa_rst_o(sr[1]), .sisa_en_o(en[1]), .busy_o(bs[1]), .done_o(dn[1]),
    .pass_o(ps[1]), .sig_q_o(sq[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, edge_n);
    end
  endtask

  // Phase of cycle c relative to the session start edge: 0 idle, 1 seed, 2 run, 3 check, 4 done.
  function automatic int phase(int i, int c);
    int o;
    if (!m_act[i]) return 0;
    o = c - m_k[i];
    if (o <= 1) return 1;
    if (o <= len_m[i] + 1) return 2;
    if (o == len_m[i] + 2) return 3;
    return 4;
  endfunction

  task automatic check_cycle(input int c);
    for (int i = 0; i < 2; i++) begin
      int q;
      q = phase(i, c);
      chk($sformatf("sisa_rst%0d", i), sr[i], q == 1);
      chk($sformatf("sisa_en%0d", i),  en[i], q == 2);
      chk($sformatf("busy%0d", i),     bs[i], q != 0);
      chk($sformatf("done%0d", i),     dn[i], q == 4);
      chk($sformatf("pass%0d", i),     ps[i], m_pass[i]);
      chk($sformatf("sig_q%0d", i),    sq[i], m_sig[i]);
      if (dn[i] === 1'b1) begin
        last_done[i] = c;
        done_cnt[i]++;
      end
    end
  endtask

  task automatic step(input bit s, input bit a, input logic [9:0] g, input logic [9:0] si);
    start = s; abort = a; golden = g; sig_in = si;
    @(posedge clk);
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        int p;
        p = phase(i, edge_n);
        if (p >= 1 && p <= 3 && a) begin
          m_act[i]  = 1'b0;
          m_pass[i] = 1'b0;
        end else begin
          if (p == 3) begin
            m_sig[i]  = si;
            m_pass[i] = (si == g);
          end
          if (p == 4) m_act[i] = 1'b0;
          if (p == 0 && s) begin
            m_act[i]  = 1'b1;
            m_k[i]    = edge_n;
            m_pass[i] = 1'b0;
          end
        end
      end
    end
    #1;
    check_cycle(edge_n + 1);
    edge_n++;
  endtask

  initial begin
    int k0;
    int d0, d1;
    logic [9:0] g, si;
    rst_n = 1'b0; start = 0; abort = 0; golden = '0; sig_in = '0;
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_k[i] = 0; m_pass[i] = 0; m_sig[i] = '0;
      last_done[i] = -1; done_cnt[i] = 0;
    end
    #3;
    check_cycle(0);
    #9 rst_n = 1'b1;

    // Matching signature: pass expected.
    k0 = edge_n;
    step(1, 0, 10'h2A5, 10'h2A5);
    repeat (30) step(0, 0, 10'h2A5, 10'h2A5);
    chk("t1_done_cyc",  last_done[0] - k0, 27);
    chk("t1_done_cyc1", last_done[1] - k0, 4);
    chk("t1_pass",      ps[0], 1'b1);
    chk("t1_sig",       sq[0], 10'h2A5);

    // Single-bit mismatch.
    k0 = edge_n;
    step(1, 0, 10'h2A5, 10'h2A4);
    repeat (30) step(0, 0, 10'h2A5, 10'h2A4);
    chk("t2_done_cyc", last_done[0] - k0, 27);
    chk("t2_pass",     ps[0], 1'b0);
    chk("t2_sig",      sq[0], 10'h2A4);

    // start held: back-to-back sessions.
    done_cnt[0] = 0; done_cnt[1] = 0;
    repeat (100) step(1, 0, 10'h2A5, 10'h2A5);
    chk("t3_sessions",  done_cnt[0], 3);
    chk("t3_sessions1", done_cnt[1], 20);
    repeat (40) step(0, 0, 10'h2A5, 10'h2A5);

    // Abort mid-RUN, then a fresh full session.
    k0 = edge_n;
    d0 = done_cnt[0];
    step(1, 0, 10'h2A5, 10'h2A5);
    repeat (9) step(0, 0, 10'h2A5, 10'h2A5);
    step(0, 1, 10'h2A5, 10'h2A5);
    chk("t4_en_low",   en[0], 1'b0);
    chk("t4_busy_low", bs[0], 1'b0);
    repeat (20) step(0, 0, 10'h2A5, 10'h2A5);
    chk("t4_no_done", done_cnt[0] - d0, 0);
    k0 = edge_n;
    step(1, 0, 10'h2A5, 10'h2A5);
    repeat (30) step(0, 0, 10'h2A5, 10'h2A5);
    chk("t4_redo_done", last_done[0] - k0, 27);
    chk("t4_redo_pass", ps[0], 1'b1);

    // Asynchronous reset between edges, mid-RUN.
    step(1, 0, 10'h2A5, 10'h2A5);
    repeat (9) step(0, 0, 10'h2A5, 10'h2A5);
    start = 0; abort = 0;
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_pass[i] = 0; m_sig[i] = '0;
    end
    check_cycle(edge_n);
    @(posedge clk);
    edge_n++;
    #2 rst_n = 1'b1;
    d0 = done_cnt[0]; d1 = done_cnt[1];
    repeat (10) step(0, 0, 10'h2A5, 10'h2A5);
    chk("t5_idle_done", done_cnt[0] - d0, 0);
    chk("t5_idle_busy", bs[0], 1'b0);

    // Randomised sessions with aborts and near-miss signatures.
    repeat (1200) begin
      g  = 10'($urandom);
      si = ($urandom_range(0, 1) == 0) ? g : (g ^ (10'd1 << $urandom_range(0, 9)));
      step($urandom_range(0, 5) == 0, $urandom_range(0, 29) == 0, g, si);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
